// File: rtl/accelerator_erase_heads.sv
// NTM erase stage: buffers w(j) and e(k), then streams M row-major and
// emits M(j,k)*(1 - w(j)*e(k)) in signed fixed point with a fixed 2-cycle latency.
module accelerator_erase_heads #(
  parameter int unsigned DATA_SIZE       = 64,
  parameter int unsigned FRACTIONAL_SIZE = 32,
  parameter int unsigned N               = 64,
  parameter int unsigned W               = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ACCELERATOR_ERASE_HEADS_START,
  output logic                 ACCELERATOR_ERASE_HEADS_READY,
  input  logic [DATA_SIZE-1:0] ACCELERATOR_ERASE_HEADS_SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] ACCELERATOR_ERASE_HEADS_SIZE_W_IN,
  input  logic                 ACCELERATOR_ERASE_HEADS_W_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] ACCELERATOR_ERASE_HEADS_W_IN,
  input  logic                 ACCELERATOR_ERASE_HEADS_E_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] ACCELERATOR_ERASE_HEADS_E_IN,
  input  logic                 ACCELERATOR_ERASE_HEADS_M_IN_J_ENABLE,
  input  logic                 ACCELERATOR_ERASE_HEADS_M_IN_K_ENABLE,
  input  logic [DATA_SIZE-1:0] ACCELERATOR_ERASE_HEADS_M_IN,
  output logic                 ACCELERATOR_ERASE_HEADS_M_OUT_J_ENABLE,
  output logic                 ACCELERATOR_ERASE_HEADS_M_OUT_K_ENABLE,
  output logic [DATA_SIZE-1:0] ACCELERATOR_ERASE_HEADS_M_OUT
);

  localparam int unsigned D   = DATA_SIZE;
  localparam int unsigned F   = FRACTIONAL_SIZE;
  localparam int unsigned PW1 = 2 * D;
  localparam int unsigned FW  = 2 * D + 1;
  localparam int unsigned PW2 = 3 * D + 1;
  localparam int unsigned NA  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WA  = (W > 1) ? $clog2(W) : 1;

  localparam logic signed [FW-1:0]  ONE     = FW'(1) << F;
  localparam logic signed [PW2-1:0] SAT_MAX = {{(PW2-D+1){1'b0}}, {(D-1){1'b1}}};
  localparam logic signed [PW2-1:0] SAT_MIN = {{(PW2-D+1){1'b1}}, {(D-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_E,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [NA-1:0] j_cnt, last_j;
  logic [WA-1:0] k_cnt, last_k;
  logic          w_wr, e_wr, m_acc, ready_d;

  logic signed [D-1:0] wbuf [N];
  logic signed [D-1:0] ebuf [W];

  logic [D-1:0] n_clamp, w_clamp;
  logic         size_zero;

  logic                 s1_valid, s1_first;
  logic signed [D-1:0]  s1_m;
  logic signed [FW-1:0] s1_f;
  logic                 s2_valid, s2_first;
  logic [D-1:0]         s2_r;

  // Row marker on the input is informational; the internal counters decide.
  logic unused_m_in_j;
  assign unused_m_in_j = ACCELERATOR_ERASE_HEADS_M_IN_J_ENABLE;

  assign n_clamp = (ACCELERATOR_ERASE_HEADS_SIZE_N_IN > D'(N)) ? D'(N)
                                                               : ACCELERATOR_ERASE_HEADS_SIZE_N_IN;
  assign w_clamp = (ACCELERATOR_ERASE_HEADS_SIZE_W_IN > D'(W)) ? D'(W)
                                                               : ACCELERATOR_ERASE_HEADS_SIZE_W_IN;
  assign size_zero = (ACCELERATOR_ERASE_HEADS_SIZE_N_IN == '0) ||
                     (ACCELERATOR_ERASE_HEADS_SIZE_W_IN == '0);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_d;
  end

  // Next-state and phase strobes
  always_comb begin
    state_d = state;
    w_wr    = 1'b0;
    e_wr    = 1'b0;
    m_acc   = 1'b0;
    ready_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (ACCELERATOR_ERASE_HEADS_START) state_d = size_zero ? S_DONE : S_LOAD_W;
      end
      S_LOAD_W: begin
        if (ACCELERATOR_ERASE_HEADS_W_IN_ENABLE) begin
          w_wr = 1'b1;
          if (j_cnt == last_j) state_d = S_LOAD_E;
        end
      end
      S_LOAD_E: begin
        if (ACCELERATOR_ERASE_HEADS_E_IN_ENABLE) begin
          e_wr = 1'b1;
          if (k_cnt == last_k) state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (ACCELERATOR_ERASE_HEADS_M_IN_K_ENABLE) begin
          m_acc = 1'b1;
          if ((j_cnt == last_j) && (k_cnt == last_k)) state_d = S_DRAIN;
        end
      end
      // Leaving once stage 1 is empty lines READY up one cycle after the last output.
      S_DRAIN: begin
        if (!s1_valid) state_d = S_DONE;
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clamped sizes kept as last index
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_j <= '0;
      last_k <= '0;
    end else if ((state == S_IDLE) && ACCELERATOR_ERASE_HEADS_START) begin
      last_j <= NA'(n_clamp - D'(1));
      last_k <= WA'(w_clamp - D'(1));
    end
  end

  // Index counters shared by load and stream phases; each phase leaves them at 0
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      j_cnt <= '0;
      k_cnt <= '0;
    end else if (state == S_IDLE) begin
      j_cnt <= '0;
      k_cnt <= '0;
    end else begin
      if (w_wr) j_cnt <= (j_cnt == last_j) ? '0 : j_cnt + NA'(1);
      if (e_wr) k_cnt <= (k_cnt == last_k) ? '0 : k_cnt + WA'(1);
      if (m_acc) begin
        if (k_cnt == last_k) begin
          k_cnt <= '0;
          j_cnt <= (j_cnt == last_j) ? '0 : j_cnt + NA'(1);
        end else begin
          k_cnt <= k_cnt + WA'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) wbuf[j_cnt] <= ACCELERATOR_ERASE_HEADS_W_IN;
    if (e_wr) ebuf[k_cnt] <= ACCELERATOR_ERASE_HEADS_E_IN;
  end

  // Stage 1: erase factor f = ONE - (w*e >>> F)
  logic signed [D-1:0]   w_sel, e_sel;
  logic signed [PW1-1:0] we_prod, we_shift;
  logic signed [FW-1:0]  f_c;

  assign w_sel    = wbuf[j_cnt];
  assign e_sel    = ebuf[k_cnt];
  assign we_prod  = PW1'(w_sel) * PW1'(e_sel);
  assign we_shift = we_prod >>> F;
  assign f_c      = ONE - FW'(we_shift);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_m     <= '0;
      s1_f     <= '0;
    end else begin
      s1_valid <= m_acc;
      if (m_acc) begin
        s1_first <= (k_cnt == '0);
        s1_m     <= ACCELERATOR_ERASE_HEADS_M_IN;
        s1_f     <= f_c;
      end
    end
  end

  // Stage 2: r = (M*f) >>> F, saturated only here
  logic signed [PW2-1:0] mf_prod, mf_shift;
  logic [D-1:0]          r_sat;

  assign mf_prod  = PW2'(s1_m) * PW2'(s1_f);
  assign mf_shift = mf_prod >>> F;

  always_comb begin
    r_sat = mf_shift[D-1:0];
    if (mf_shift > SAT_MAX)      r_sat = SAT_MAX[D-1:0];
    else if (mf_shift < SAT_MIN) r_sat = SAT_MIN[D-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_r     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      if (s1_valid) s2_r <= r_sat;
    end
  end

  // Output registers; M_OUT holds between valids
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ACCELERATOR_ERASE_HEADS_READY          <= 1'b0;
      ACCELERATOR_ERASE_HEADS_M_OUT_J_ENABLE <= 1'b0;
      ACCELERATOR_ERASE_HEADS_M_OUT_K_ENABLE <= 1'b0;
      ACCELERATOR_ERASE_HEADS_M_OUT          <= '0;
    end else begin
      ACCELERATOR_ERASE_HEADS_READY          <= ready_d;
      ACCELERATOR_ERASE_HEADS_M_OUT_J_ENABLE <= s2_valid & s2_first;
      ACCELERATOR_ERASE_HEADS_M_OUT_K_ENABLE <= s2_valid;
      if (s2_valid) ACCELERATOR_ERASE_HEADS_M_OUT <= s2_r;
    end
  end

endmodule

// File: tb/tb_accelerator_erase_heads.sv
// Self-checking bench for accelerator_erase_heads (DATA_SIZE=16, FRACTIONAL_SIZE=8, N=4, W=8)
// against an arithmetic reference model of the erase equation.
module tb_accelerator_erase_heads;

  localparam int unsigned NMAX = 4;
  localparam int unsigned WMAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ready;
  logic [15:0] size_n, size_w;
  logic        w_en, e_en, mj_en, mk_en;
  logic [15:0] w_in, e_in, m_in;
  logic        oj_en, ok_en;
  logic [15:0] m_out;

  accelerator_erase_heads #(
    .DATA_SIZE(16), .FRACTIONAL_SIZE(8), .N(NMAX), .W(WMAX)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .ACCELERATOR_ERASE_HEADS_START(start),
    .ACCELERATOR_ERASE_HEADS_READY(ready),
    .ACCELERATOR_ERASE_HEADS_SIZE_N_IN(size_n),
    .ACCELERATOR_ERASE_HEADS_SIZE_W_IN(size_w),
    .ACCELERATOR_ERASE_HEADS_W_IN_ENABLE(w_en),
    .ACCELERATOR_ERASE_HEADS_W_IN(w_in),
    .ACCELERATOR_ERASE_HEADS_E_IN_ENABLE(e_en),
    .ACCELERATOR_ERASE_HEADS_E_IN(e_in),
    .ACCELERATOR_ERASE_HEADS_M_IN_J_ENABLE(mj_en),
    .ACCELERATOR_ERASE_HEADS_M_IN_K_ENABLE(mk_en),
    .ACCELERATOR_ERASE_HEADS_M_IN(m_in),
    .ACCELERATOR_ERASE_HEADS_M_OUT_J_ENABLE(oj_en),
    .ACCELERATOR_ERASE_HEADS_M_OUT_K_ENABLE(ok_en),
    .ACCELERATOR_ERASE_HEADS_M_OUT(m_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] v;
    logic        j;
    int          c;
  } out_t;

  out_t out_q[$];
  int   rdy_q[$];

  // Record every output valid and READY with the cycle it was seen in
  always @(negedge clk) begin
    if (ok_en === 1'b1) out_q.push_back('{v: m_out, j: oj_en, c: cyc});
    if (ready === 1'b1) rdy_q.push_back(cyc);
  end

  int checks = 0;
  int failures = 0;

  logic [15:0] wv [16];
  logic [15:0] ev [16];
  logic [15:0] mv [128];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // M*(1 - w*e) with truncating arithmetic shifts, saturated to 16 bits
  function automatic logic [15:0] model(input logic [15:0] w, input logic [15:0] e,
                                        input logic [15:0] m);
    longint p, f, r;
    p = (longint'($signed(w)) * longint'($signed(e))) >>> 8;
    f = 256 - p;
    r = (longint'($signed(m)) * f) >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      wv[i] = 16'($urandom);
      ev[i] = 16'($urandom);
    end
    for (int i = 0; i < 128; i++) mv[i] = 16'($urandom);
  endtask

  task automatic set_basic();
    wv[0] = 16'd128; wv[1] = 16'd0;
    ev[0] = 16'd256; ev[1] = 16'd128;
    for (int i = 0; i < 4; i++) mv[i] = 16'd512;
  endtask

  // gap: 0 back-to-back, 1 stream alternates, 2 random gaps; inject adds ignored events
  task automatic run(input int sn, input int sw, input int gap, input bit inject, input string tag);
    int n, wl, ob, rb, cnt, waited, total;
    int in_edge[$];
    n  = (sn > int'(NMAX)) ? int'(NMAX) : sn;
    wl = (sw > int'(WMAX)) ? int'(WMAX) : sw;
    total = n * wl;
    ob = out_q.size();
    rb = rdy_q.size();
    step();
    start = 1'b1; size_n = 16'(sn); size_w = 16'(sw);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (inject || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        e_en = inject; e_in = 16'($urandom); mk_en = inject; m_in = 16'($urandom);
        step();
        e_en = 1'b0; mk_en = 1'b0;
      end
      w_en = 1'b1; w_in = wv[i];
      step();
      w_en = 1'b0;
    end
    for (int i = 0; i < wl; i++) begin
      if (inject || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        w_en = inject; w_in = 16'($urandom);
        step();
        w_en = 1'b0;
      end
      e_en = 1'b1; e_in = ev[i];
      step();
      e_en = 1'b0;
    end
    for (int i = 0; i < total; i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 1) == 1)) step();
      mk_en = 1'b1; m_in = mv[i]; mj_en = (i % wl == 0);
      if (inject && i == 1) begin
        start = 1'b1; size_n = 16'd1; size_w = 16'd1;
      end
      in_edge.push_back(cyc + 1);
      step();
      mk_en = 1'b0; mj_en = 1'b0; start = 1'b0;
    end
    waited = 0;
    while (rdy_q.size() == rb && waited < 40) begin
      step();
      waited++;
    end
    cnt = out_q.size() - ob;
    check($sformatf("%s_ready_count", tag), 64'(rdy_q.size() - rb), 64'(1));
    check($sformatf("%s_out_count", tag), 64'(cnt), 64'(total));
    for (int i = 0; i < cnt && i < total; i++) begin
      check($sformatf("%s_val%0d", tag, i), 64'(out_q[ob+i].v),
            64'(model(wv[i/wl], ev[i%wl], mv[i])));
      check($sformatf("%s_jen%0d", tag, i), 64'(out_q[ob+i].j), 64'(i % wl == 0));
      check($sformatf("%s_lat%0d", tag, i), 64'(out_q[ob+i].c), 64'(in_edge[i] + 2));
    end
    if (rdy_q.size() > rb && cnt > 0)
      check($sformatf("%s_ready_cycle", tag), 64'(rdy_q[rb]), 64'(out_q[ob+cnt-1].c + 1));
  endtask

  initial begin
    int ob, rb, c;
    rst_n = 1'b0; start = 1'b0; size_n = '0; size_w = '0;
    w_en = 1'b0; e_en = 1'b0; mj_en = 1'b0; mk_en = 1'b0;
    w_in = '0; e_in = '0; m_in = '0;
    repeat (3) step();
    check("reset_ready", 64'(ready), 64'(0));
    check("reset_k_en", 64'(ok_en), 64'(0));
    check("reset_j_en", 64'(oj_en), 64'(0));
    check("reset_m_out", 64'(m_out), 64'(0));
    rst_n = 1'b1;
    step();

    // Basic erase with known values
    set_basic();
    run(2, 2, 0, 1'b0, "basic");
    check("basic_v0_const", 64'(out_q[0].v), 64'(256));
    check("basic_v1_const", 64'(out_q[1].v), 64'(384));

    // Saturation both directions, back-to-back runs
    wv[0] = 16'hFF00; ev[0] = 16'd256;
    mv[0] = 16'h7F00;
    run(1, 1, 0, 1'b0, "sat_pos");
    check("sat_pos_const", 64'(out_q[out_q.size()-1].v), 64'(16'h7FFF));
    mv[0] = 16'h8100;
    run(1, 1, 0, 1'b0, "sat_neg");
    check("sat_neg_const", 64'(out_q[out_q.size()-1].v), 64'(16'h8000));

    // Gapped stream with row count clamped to N
    fill_random();
    run(100, 3, 1, 1'b0, "gap_clamp");

    // Zero size: READY two cycles after START, no outputs, stray W enables ignored
    ob = out_q.size(); rb = rdy_q.size();
    step();
    start = 1'b1; size_n = 16'd3; size_w = 16'd0; c = cyc;
    step();
    start = 1'b0;
    repeat (2) begin
      w_en = 1'b1; w_in = 16'($urandom);
      step();
      w_en = 1'b0;
      step();
    end
    check("zero_ready_count", 64'(rdy_q.size() - rb), 64'(1));
    if (rdy_q.size() > rb) check("zero_ready_cycle", 64'(rdy_q[rb]), 64'(c + 2));
    check("zero_out_count", 64'(out_q.size() - ob), 64'(0));

    // Reset in the middle of the stream after three outputs
    fill_random();
    ob = out_q.size(); rb = rdy_q.size();
    step();
    start = 1'b1; size_n = 16'd2; size_w = 16'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin w_en = 1'b1; w_in = wv[i]; step(); w_en = 1'b0; end
    for (int i = 0; i < 4; i++) begin e_en = 1'b1; e_in = ev[i]; step(); e_en = 1'b0; end
    for (int i = 0; i < 8; i++) begin
      mk_en = 1'b1; m_in = mv[i]; mj_en = (i % 4 == 0);
      step();
      mk_en = 1'b0; mj_en = 1'b0;
      if (out_q.size() - ob >= 3) break;
    end
    check("rst_pre_count", 64'(out_q.size() - ob), 64'(3));
    rst_n = 1'b0;
    #1;
    check("rst_k_en", 64'(ok_en), 64'(0));
    check("rst_j_en", 64'(oj_en), 64'(0));
    check("rst_m_out", 64'(m_out), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check("rst_post_count", 64'(out_q.size() - ob), 64'(3));
    check("rst_no_ready", 64'(rdy_q.size() - rb), 64'(0));
    set_basic();
    run(2, 2, 0, 1'b0, "post_reset");

    // Ignored START during stream and E/W enables outside their phase
    set_basic();
    run(2, 2, 0, 1'b1, "inject");

    // Randomized sizes, data, gaps and injected events
    for (int r = 0; r < 5; r++) begin
      fill_random();
      run(int'($urandom_range(1, 6)), int'($urandom_range(1, 10)), 2,
          1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

    // Nothing more may appear once idle
    ob = out_q.size(); rb = rdy_q.size();
    repeat (6) step();
    check("idle_out_count", 64'(out_q.size() - ob), 64'(0));
    check("idle_ready_count", 64'(rdy_q.size() - rb), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
